// File: rtl/ex_alu_muldiv.sv
// Execute stage: ALU result mux, load/store address, HI/LO registers
// and a 32-step restoring divider that stalls upstream while busy.
module ex_alu_muldiv #(
   parameter int DIV_ITERS = 32,
   parameter bit TRAP_OVF  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  aluop_i,
   input  logic [3:0]  lsop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic        stall_i,
   output logic [31:0] wdata_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [3:0]  lsop_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        stallreq_o
);

   localparam logic [5:0] ALU_NOP   = 6'd0;
   localparam logic [5:0] ALU_ADD   = 6'd1;
   localparam logic [5:0] ALU_ADDU  = 6'd2;
   localparam logic [5:0] ALU_SUB   = 6'd3;
   localparam logic [5:0] ALU_SUBU  = 6'd4;
   localparam logic [5:0] ALU_SLT   = 6'd5;
   localparam logic [5:0] ALU_SLTU  = 6'd6;
   localparam logic [5:0] ALU_AND   = 6'd7;
   localparam logic [5:0] ALU_OR    = 6'd8;
   localparam logic [5:0] ALU_XOR   = 6'd9;
   localparam logic [5:0] ALU_NOR   = 6'd10;
   localparam logic [5:0] ALU_SLL   = 6'd11;
   localparam logic [5:0] ALU_SLLV  = 6'd12;
   localparam logic [5:0] ALU_SRL   = 6'd13;
   localparam logic [5:0] ALU_SRLV  = 6'd14;
   localparam logic [5:0] ALU_SRA   = 6'd15;
   localparam logic [5:0] ALU_SRAV  = 6'd16;
   localparam logic [5:0] ALU_LUI   = 6'd17;
   localparam logic [5:0] ALU_LINK  = 6'd18;
   localparam logic [5:0] ALU_MFHI  = 6'd19;
   localparam logic [5:0] ALU_MFLO  = 6'd20;
   localparam logic [5:0] ALU_MTHI  = 6'd21;
   localparam logic [5:0] ALU_MTLO  = 6'd22;
   localparam logic [5:0] ALU_MULT  = 6'd23;
   localparam logic [5:0] ALU_MULTU = 6'd24;
   localparam logic [5:0] ALU_DIV   = 6'd25;
   localparam logic [5:0] ALU_DIVU  = 6'd26;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } div_state_t;

   div_state_t  state_q, state_d;
   logic [31:0] hi_q, lo_q;
   logic [31:0] dvd_q, dvs_q, rem_q;
   logic [4:0]  cnt_q;
   logic        neg_quot_q, neg_rem_q;

   logic [31:0] sum, diff;
   logic        ovf_add, ovf_sub;
   logic        is_div, div_signed;
   logic [31:0] a_abs, b_abs;
   logic [32:0] rem_sh, trial;
   logic        q_bit;
   logic [31:0] rem_nx, dvd_nx, quot_fix, rem_fix;
   logic [63:0] prod_s, prod_u;
   logic        busy, div_load, div_zero, div_step, div_fin;
   logic        hilo_en;

   assign sum  = reg1_i + reg2_i;
   assign diff = reg1_i - reg2_i;

   assign ovf_add = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
   assign ovf_sub = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);

   assign wd_o        = wd_i;
   assign lsop_o      = lsop_i;
   assign mem_addr_o  = sum;
   assign mem_wdata_o = store_data_i;

   assign wreg_o = wreg_i & ~(TRAP_OVF &
                   (((aluop_i == ALU_ADD) & ovf_add) |
                    ((aluop_i == ALU_SUB) & ovf_sub)));

   assign prod_s = $signed({{32{reg1_i[31]}}, reg1_i}) *
                   $signed({{32{reg2_i[31]}}, reg2_i});
   assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

   always_comb begin
      wdata_o = 32'd0;
      case (aluop_i)
         ALU_ADD, ALU_ADDU: wdata_o = sum;
         ALU_SUB, ALU_SUBU: wdata_o = diff;
         ALU_SLT:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
         ALU_SLTU: wdata_o = {31'd0, reg1_i < reg2_i};
         ALU_AND:  wdata_o = reg1_i & reg2_i;
         ALU_OR:   wdata_o = reg1_i | reg2_i;
         ALU_XOR:  wdata_o = reg1_i ^ reg2_i;
         ALU_NOR:  wdata_o = ~(reg1_i | reg2_i);
         ALU_SLL, ALU_SLLV: wdata_o = reg2_i << reg1_i[4:0];
         ALU_SRL, ALU_SRLV: wdata_o = reg2_i >> reg1_i[4:0];
         ALU_SRA, ALU_SRAV:
            wdata_o = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
         ALU_LUI:  wdata_o = {reg2_i[15:0], 16'h0};
         ALU_LINK: wdata_o = sum;
         ALU_MFHI: wdata_o = hi_q;
         ALU_MFLO: wdata_o = lo_q;
         default:  wdata_o = 32'd0;
      endcase
   end

   assign is_div     = (aluop_i == ALU_DIV) || (aluop_i == ALU_DIVU);
   assign div_signed = (aluop_i == ALU_DIV);
   assign a_abs = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
   assign b_abs = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;

   // one restoring step: shift in next dividend bit, keep difference if non-negative
   assign rem_sh   = {rem_q, dvd_q[31]};
   assign trial    = rem_sh - {1'b0, dvs_q};
   assign q_bit    = ~trial[32];
   assign rem_nx   = q_bit ? trial[31:0] : rem_sh[31:0];
   assign dvd_nx   = {dvd_q[30:0], q_bit};
   assign quot_fix = neg_quot_q ? -dvd_nx : dvd_nx;
   assign rem_fix  = neg_rem_q ? -rem_nx : rem_nx;

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      div_load = 1'b0;
      div_zero = 1'b0;
      div_step = 1'b0;
      div_fin  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (is_div) begin
               busy = 1'b1;
               if (reg2_i == 32'd0) begin
                  div_zero = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  div_load = 1'b1;
                  state_d  = S_CALC;
               end
            end
         end
         S_CALC: begin
            busy     = 1'b1;
            div_step = 1'b1;
            if (cnt_q == 5'(DIV_ITERS - 1)) begin
               div_fin = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!stall_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stallreq_o = busy & ~rst;
   assign hilo_en    = ~stall_i & ~busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q      <= 32'd0;
         dvs_q      <= 32'd0;
         rem_q      <= 32'd0;
         cnt_q      <= 5'd0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else if (div_load) begin
         dvd_q      <= a_abs;
         dvs_q      <= b_abs;
         rem_q      <= 32'd0;
         cnt_q      <= 5'd0;
         neg_quot_q <= div_signed & (reg1_i[31] ^ reg2_i[31]);
         neg_rem_q  <= div_signed & reg1_i[31];
      end else if (div_step) begin
         dvd_q <= dvd_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (div_fin) begin
         hi_q <= rem_fix;
         lo_q <= quot_fix;
      end else if (div_zero) begin
         hi_q <= reg1_i;
         lo_q <= 32'hFFFF_FFFF;
      end else if (hilo_en) begin
         case (aluop_i)
            ALU_MTHI: hi_q <= reg1_i;
            ALU_MTLO: lo_q <= reg1_i;
            ALU_MULT: {hi_q, lo_q} <= prod_s;
            ALU_MULTU: {hi_q, lo_q} <= prod_u;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed-vector bench for ex_alu_muldiv: ALU ops, overflow gating,
// HI/LO moves, multiply, divider latency, divide-by-zero, reset, stall.
module tb_ex_alu_muldiv;

   localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, ADDU = 6'd2;
   localparam logic [5:0] SUB = 6'd3, SLT = 6'd5, SLTU = 6'd6;
   localparam logic [5:0] NOR = 6'd10, SLL = 6'd11, SRL = 6'd13;
   localparam logic [5:0] SRA = 6'd15, LUI = 6'd17;
   localparam logic [5:0] MFHI = 6'd19, MFLO = 6'd20, MTHI = 6'd21;
   localparam logic [5:0] MULT = 6'd23, MULTU = 6'd24;
   localparam logic [5:0] DIV = 6'd25, DIVU = 6'd26;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  aluop_i;
   logic [3:0]  lsop_i;
   logic [31:0] reg1_i, reg2_i, store_data_i;
   logic [4:0]  wd_i;
   logic        wreg_i, stall_i;
   logic [31:0] wdata_o, mem_addr_o, mem_wdata_o;
   logic [4:0]  wd_o;
   logic        wreg_o, stallreq_o;
   logic [3:0]  lsop_o;

   int checks = 0;
   int failures = 0;
   int n;

   always #5 clk = ~clk;

   ex_alu_muldiv dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .lsop_i(lsop_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .store_data_i(store_data_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .stall_i(stall_i),
      .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .lsop_o(lsop_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .stallreq_o(stallreq_o)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [5:0] a, input logic [31:0] r1,
                     input logic [31:0] r2);
      aluop_i = a;
      reg1_i  = r1;
      reg2_i  = r2;
      #1;
   endtask

   // counts cycles with stallreq_o high; returns at the negedge where it drops
   task automatic wait_div(output int cnt);
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!stallreq_o) break;
         cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] hi,
                            input logic [31:0] lo);
      op(MFHI, 0, 0);
      chk({tag, "_hi"}, wdata_o, hi);
      op(MFLO, 0, 0);
      chk({tag, "_lo"}, wdata_o, lo);
   endtask

   initial begin
      rst = 1'b1;
      aluop_i = NOP; lsop_i = 4'h3; reg1_i = 0; reg2_i = 0;
      store_data_i = 32'hA5A5_1234; wd_i = 5'd9; wreg_i = 1'b1;
      stall_i = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      #1;
      chk("rst_stallreq", stallreq_o, 0);
      read_hilo("rst", 0, 0);

      op(ADD, 32'h7FFF_FFFF, 32'h1);
      chk("add_ovf_data", wdata_o, 32'h8000_0000);
      chk("add_ovf_wreg", wreg_o, 0);
      chk("mem_addr", mem_addr_o, 32'h8000_0000);
      chk("pass_through", {wd_o, lsop_o, mem_wdata_o},
          {5'd9, 4'h3, 32'hA5A5_1234});
      op(ADDU, 32'h7FFF_FFFF, 32'h1);
      chk("addu_wreg", wreg_o, 1);
      op(SUB, 32'h8000_0000, 32'h1);
      chk("sub_ovf_data", wdata_o, 32'h7FFF_FFFF);
      chk("sub_ovf_wreg", wreg_o, 0);
      op(SUB, 32'h5, 32'h7);
      chk("sub_ok", {wreg_o, wdata_o}, {1'b1, 32'hFFFF_FFFE});
      op(SLT, 32'hFFFF_FFFF, 32'h1);
      chk("slt", wdata_o, 1);
      op(SLTU, 32'hFFFF_FFFF, 32'h1);
      chk("sltu", wdata_o, 0);
      op(SRA, 32'd4, 32'h8000_0000);
      chk("sra", wdata_o, 32'hF800_0000);
      op(SRL, 32'd4, 32'h8000_0000);
      chk("srl", wdata_o, 32'h0800_0000);
      op(SLL, 32'd31, 32'h1);
      chk("sll", wdata_o, 32'h8000_0000);
      op(LUI, 32'h0, 32'hFFFF_1234);
      chk("lui", wdata_o, 32'h1234_0000);
      op(NOR, 32'h0, 32'h0);
      chk("nor", wdata_o, 32'hFFFF_FFFF);

      op(MULT, 32'hFFFF_FFFE, 32'h3);
      step();
      read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      op(MULTU, 32'hFFFF_FFFE, 32'h3);
      step();
      read_hilo("multu", 32'h2, 32'hFFFF_FFFA);

      stall_i = 1'b1;
      op(MTHI, 32'hABCD, 0);
      step();
      stall_i = 1'b0;
      read_hilo("mthi_stalled", 32'h2, 32'hFFFF_FFFA);
      op(MTHI, 32'hABCD, 0);
      step();
      read_hilo("mthi", 32'hABCD, 32'hFFFF_FFFA);

      op(DIV, 32'hFFFF_FFF9, 32'h2);
      wait_div(n);
      chk("div_stall_cycles", n, 33);
      step();
      read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      op(DIVU, 32'h5, 32'h0);
      wait_div(n);
      chk("div0_stall_cycles", n, 1);
      step();
      read_hilo("div0", 32'h5, 32'hFFFF_FFFF);

      op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_div(n);
      chk("div_min_cycles", n, 33);
      step();
      read_hilo("div_min", 32'h0, 32'h8000_0000);

      op(DIVU, 32'd100, 32'd3);
      step();
      repeat (10) step();
      chk("mid_calc_busy", stallreq_o, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_stallreq", stallreq_o, 0);
      read_hilo("rst_mid", 0, 0);
      step();
      rst = 1'b0;
      op(DIVU, 32'd64, 32'd8);
      wait_div(n);
      chk("divu_after_rst_cycles", n, 33);
      step();
      read_hilo("divu_after_rst", 32'd0, 32'd8);

      op(DIV, 32'd100, 32'hFFFF_FFF9);
      wait_div(n);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("done_held_stallreq", stallreq_o, 0);
      end
      stall_i = 1'b0;
      step();
      read_hilo("div_stalled", 32'd2, 32'hFFFF_FFF2);
      chk("idle_after_done", stallreq_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
